// File: rtl/wb_timeout_interconnect.sv
// Single-master Wishbone interconnect: base-address decode to SLAVES one-hot selects,
// registered request forwarding, and a per-access watchdog so an unacknowledged access always terminates.
module wb_timeout_interconnect #(
    parameter int                    SLAVES     = 5,
    parameter int                    BASE_WIDTH = 24,
    parameter int                    SUB_WIDTH  = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TIMEOUT    = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [BASE_WIDTH+SUB_WIDTH-1:0]  m_adr_i,
    input  logic [DATA_WIDTH-1:0]            m_dat_i,
    input  logic                             m_we_i,
    input  logic                             m_stb_i,
    input  logic                             m_cyc_i,
    output logic [DATA_WIDTH-1:0]            m_dat_o,
    output logic                             m_ack_o,
    output logic                             m_err_o,
    input  logic [SLAVES*BASE_WIDTH-1:0]     slave_base_i,
    output logic [SUB_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    output logic                             s_we_o,
    output logic [SLAVES-1:0]                s_cyc_o,
    output logic [SLAVES-1:0]                s_stb_o,
    input  logic [SLAVES*DATA_WIDTH-1:0]     s_dat_i,
    input  logic [SLAVES-1:0]                s_ack_i,
    output logic [15:0]                      timeout_count_o,
    output logic [BASE_WIDTH+SUB_WIDTH-1:0]  last_err_adr_o
);
    localparam int          ADR_WIDTH = BASE_WIDTH + SUB_WIDTH;
    localparam int          SEL_WIDTH = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DECODE, ACTIVE, RESP} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ADR_WIDTH-1:0]   r_adr;
    logic [SEL_WIDTH-1:0]   r_sel;
    logic [15:0]            r_wdog;
    logic                   r_err;

    logic [SLAVES-1:0]      w_match;
    logic                   w_hit;
    logic [SEL_WIDTH-1:0]   w_hit_idx;
    logic [DATA_WIDTH-1:0]  w_s_dat [SLAVES];
    logic                   w_req;
    logic                   w_sel_ack;
    logic                   w_wdog_last;

    genvar gi;
    generate
        for (gi = 0; gi < SLAVES; gi++) begin : g_slave
            assign w_match[gi] = (r_adr[ADR_WIDTH-1 -: BASE_WIDTH] ==
                                  slave_base_i[gi*BASE_WIDTH +: BASE_WIDTH]);
            assign w_s_dat[gi] = s_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        w_hit_idx = '0;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if (w_match[i]) w_hit_idx = SEL_WIDTH'(i);
        end
    end

    assign w_hit       = |w_match;
    assign w_req       = m_cyc_i && m_stb_i;
    assign w_sel_ack   = s_ack_i[r_sel];
    assign w_wdog_last = (r_wdog == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next_state = DECODE;
            DECODE:  w_next_state = w_hit ? ACTIVE : RESP;
            ACTIVE: begin
                if (!m_cyc_i)                      w_next_state = IDLE;
                else if (w_sel_ack || w_wdog_last) w_next_state = RESP;
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Strobes and acks are decoded from registered state only, so they cannot glitch.
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        m_ack_o = 1'b0;
        m_err_o = 1'b0;
        if (r_state == ACTIVE) begin
            for (int i = 0; i < SLAVES; i++) begin
                s_cyc_o[i] = (r_sel == SEL_WIDTH'(i));
                s_stb_o[i] = (r_sel == SEL_WIDTH'(i));
            end
        end
        if (r_state == RESP) begin
            m_ack_o = !r_err;
            m_err_o = r_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adr           <= '0;
            r_sel           <= '0;
            r_wdog          <= '0;
            r_err           <= 1'b0;
            m_dat_o         <= '0;
            s_adr_o         <= '0;
            s_dat_o         <= '0;
            s_we_o          <= 1'b0;
            timeout_count_o <= '0;
            last_err_adr_o  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_adr   <= m_adr_i;
                        s_adr_o <= m_adr_i[SUB_WIDTH-1:0];
                        s_dat_o <= m_dat_i;
                        s_we_o  <= m_we_i;
                    end
                end
                DECODE: begin
                    if (w_hit) begin
                        r_sel  <= w_hit_idx;
                        r_wdog <= '0;
                    end else begin
                        m_dat_o        <= ERR_DATA;
                        r_err          <= 1'b1;
                        last_err_adr_o <= r_adr;
                    end
                end
                ACTIVE: begin
                    if (!m_cyc_i) begin
                        r_wdog <= '0;
                    end else if (w_sel_ack) begin
                        m_dat_o <= w_s_dat[r_sel];
                        r_err   <= 1'b0;
                    end else if (w_wdog_last) begin
                        m_dat_o        <= ERR_DATA;
                        r_err          <= 1'b1;
                        last_err_adr_o <= r_adr;
                        if (timeout_count_o != 16'hFFFF)
                            timeout_count_o <= timeout_count_o + 16'd1;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_timeout_interconnect.sv
// Directed bench for wb_timeout_interconnect: behavioural slaves, a response scoreboard
// and immediate assertions on response cycle, data, strobe pattern and error bookkeeping.
module tb_wb_timeout_interconnect;
    localparam int NS = 5;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       m_adr_i;
    logic [31:0]       m_dat_i;
    logic              m_we_i, m_stb_i, m_cyc_i;
    logic [31:0]       m_dat_o;
    logic              m_ack_o, m_err_o;
    logic [NS*24-1:0]  slave_base_i;
    logic [7:0]        s_adr_o;
    logic [31:0]       s_dat_o;
    logic              s_we_o;
    logic [NS-1:0]     s_cyc_o, s_stb_o;
    logic [NS*32-1:0]  s_dat_i;
    logic [NS-1:0]     s_ack_i;
    logic [15:0]       timeout_count_o;
    logic [31:0]       last_err_adr_o;

    // Slave behaviour: 0 = never ack, 1 = registered ack one cycle after strobe,
    // 2 = combinational ack once the strobe has been high slv_delay cycles.
    logic [1:0]        slv_mode [NS];
    int                slv_delay [NS];
    logic              foreign_ack;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          cyc;
        int          slen;
        logic [4:0]  mask;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    wb_timeout_interconnect #(.SLAVES(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_we_i(m_we_i),
        .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .slave_base_i(slave_base_i),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .timeout_count_o(timeout_count_o), .last_err_adr_o(last_err_adr_o)
    );

    function automatic logic [31:0] slave_data(input int idx);
        if (idx == 2) return 32'h12345678;
        return 32'hA5A50000 | 32'(idx);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_slv
            logic ack_q;
            int   cnt;
            assign slave_base_i[gi*24 +: 24] = 24'h800000 + 24'(gi);
            assign s_dat_i[gi*32 +: 32]      = slave_data(gi);
            always @(posedge clk) begin
                if (rst) begin
                    ack_q <= 1'b0;
                    cnt   <= 0;
                end else begin
                    ack_q <= s_stb_o[gi] && !ack_q;
                    cnt   <= s_stb_o[gi] ? cnt + 1 : 0;
                end
            end
            assign s_ack_i[gi] = (slv_mode[gi] == 2'd1 && ack_q) ||
                                 (slv_mode[gi] == 2'd2 && s_stb_o[gi] && cnt == slv_delay[gi]) ||
                                 (gi == 3 && foreign_ack);
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_m_dat"},  64'(m_dat_o), 64'd0);
        check({p, "_m_ack"},  64'(m_ack_o), 64'd0);
        check({p, "_m_err"},  64'(m_err_o), 64'd0);
        check({p, "_s_adr"},  64'(s_adr_o), 64'd0);
        check({p, "_s_dat"},  64'(s_dat_o), 64'd0);
        check({p, "_s_we"},   64'(s_we_o), 64'd0);
        check({p, "_s_cyc"},  64'(s_cyc_o), 64'd0);
        check({p, "_s_stb"},  64'(s_stb_o), 64'd0);
        check({p, "_to_cnt"}, 64'(timeout_count_o), 64'd0);
        check({p, "_lerr"},   64'(last_err_adr_o), 64'd0);
    endtask

    // One master access; the expected response is queued at drive time and popped on response.
    task automatic access(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic we, input logic exp_err, input logic [31:0] exp_dat,
                          input int exp_cyc, input int exp_slen, input logic [4:0] exp_mask);
        exp_t e;
        logic got, rerr;
        int   rcyc, slen, bad;
        sb.push_back('{exp_err, exp_dat, exp_cyc, exp_slen, exp_mask});
        @(posedge clk); #1;
        m_adr_i = adr; m_dat_i = dat; m_we_i = we; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        got = 1'b0; rerr = 1'b0; rcyc = -1; slen = 0; bad = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (s_stb_o != '0 || s_cyc_o != '0) begin
                slen++;
                if (s_stb_o !== exp_mask || s_cyc_o !== exp_mask) bad++;
            end
            if (c == 1) begin
                check({tag, "_s_adr"}, 64'(s_adr_o), 64'(adr[7:0]));
                check({tag, "_s_dat"}, 64'(s_dat_o), 64'(dat));
                check({tag, "_s_we"},  64'(s_we_o),  64'(we));
            end
            if (m_ack_o || m_err_o) begin
                got  = 1'b1;
                rcyc = c;
                rerr = m_err_o;
                if (m_ack_o && m_err_o) bad++;
            end
        end
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        e = sb.pop_front();
        check({tag, "_responded"}, 64'(got), 64'd1);
        check({tag, "_resp_cycle"}, 64'(rcyc), 64'(e.cyc));
        check({tag, "_is_err"}, 64'(rerr), 64'(e.err));
        check({tag, "_m_dat"}, 64'(m_dat_o), 64'(e.dat));
        check({tag, "_strobe_len"}, 64'(slen), 64'(e.slen));
        check({tag, "_bad_strobe"}, 64'(bad), 64'd0);
        if (e.err) check({tag, "_last_err_adr"}, 64'(last_err_adr_o), 64'(adr));
        $display("txn %s adr=%h we=%0d resp_cycle=%0d err=%0d m_dat_o=%h to_cnt=%0d",
                 tag, adr, we, rcyc, rerr, m_dat_o, timeout_count_o);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; m_adr_i = '0; m_dat_i = '0; m_we_i = 1'b0; m_stb_i = 1'b0; m_cyc_i = 1'b0;
        foreign_ack = 1'b0;
        for (int i = 0; i < NS; i++) begin
            slv_mode[i] = 2'd0;
            slv_delay[i] = 0;
        end
        slv_mode[0] = 2'd1;
        slv_mode[2] = 2'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        access("rd_s2", 32'h80000210, 32'h0, 1'b0, 1'b0, 32'h12345678, 4, 2, 5'b00100);
        access("wr_s0", 32'h80000044, 32'hCAFE, 1'b1, 1'b0, slave_data(0), 4, 2, 5'b00001);
        access("miss", 32'h12345677, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 2, 0, 5'b00000);

        access("timeout1", 32'h80000120, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, TO + 2, TO, 5'b00010);
        check("to_cnt_1", 64'(timeout_count_o), 64'd1);
        for (int r = 0; r < 3; r++)
            access("timeout_rep", 32'h80000130, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, TO + 2, TO, 5'b00010);
        check("to_cnt_4", 64'(timeout_count_o), 64'd4);

        slv_mode[1] = 2'd2; slv_delay[1] = TO - 1;
        access("race", 32'h80000140, 32'h0, 1'b0, 1'b0, slave_data(1), TO + 2, TO, 5'b00010);
        check("race_to_cnt", 64'(timeout_count_o), 64'd4);
        check("race_lerr_kept", 64'(last_err_adr_o), 64'h80000130);

        slv_delay[1] = 3; foreign_ack = 1'b1;
        access("foreign", 32'h80000150, 32'h0, 1'b0, 1'b0, slave_data(1), 6, 4, 5'b00010);
        foreign_ack = 1'b0;

        // Master abort in cycle 5 of an access that would otherwise time out.
        slv_mode[1] = 2'd0;
        @(posedge clk); #1;
        m_adr_i = 32'h80000160; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(negedge clk);
        check("abort_stb_c5", 64'(s_stb_o), 64'b00010);
        seen = 1'b0;
        for (int c = 6; c <= 10; c++) begin
            @(negedge clk);
            if (c == 6) begin
                check("abort_stb_c6", 64'(s_stb_o), 64'd0);
                check("abort_cyc_c6", 64'(s_cyc_o), 64'd0);
            end
            seen = seen | m_ack_o | m_err_o;
        end
        check("abort_no_resp", 64'(seen), 64'd0);
        check("abort_to_cnt", 64'(timeout_count_o), 64'd4);
        $display("txn abort adr=80000160 no_resp=%0d", !seen);
        access("after_abort", 32'h80000211, 32'h0, 1'b0, 1'b0, 32'h12345678, 4, 2, 5'b00100);

        // One-cycle reset while slave 1 is being strobed.
        @(posedge clk); #1;
        m_adr_i = 32'h80000170; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        $display("txn reset_mid_active adr=80000170 to_cnt=%0d", timeout_count_o);
        access("after_rst", 32'h80000212, 32'h0, 1'b0, 1'b0, 32'h12345678, 4, 2, 5'b00100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end
endmodule
